// File: rtl/clock_gate_ctrl.sv
// Idle-detect / wake controller for one clock gater cell, clocked by the free-running clock.
// Gates after a programmable idle run; wakes through a fixed-length WAKE before granting ACK.
module clock_gate_ctrl #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IDLE_CNT_W  = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned GCNT_W      = 16
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    ack,
    input  logic [NUM_REQ-1:0]    busy,
    input  logic                  cfg_auto_en,
    input  logic                  cfg_force_on,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh,
    input  logic                  cfg_cnt_clr,
    output logic                  en,
    output logic [1:0]            state,
    output logic [GCNT_W-1:0]     gated_cnt
);

    localparam int unsigned WakeW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        StOn   = 2'b00,
        StIdle = 2'b01,
        StOff  = 2'b10,
        StWake = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WakeW-1:0]      wake_cnt_q, wake_cnt_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  en_q, en_d;
    logic [GCNT_W-1:0]     gated_cnt_q, gated_cnt_d;
    logic                  activity;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        ack_d      = '0;
        activity   = (|req) | (|busy) | cfg_force_on | ~cfg_auto_en;

        unique case (state_q)
            StOn: begin
                ack_d      = req;
                idle_cnt_d = '0;
                if (!activity) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // Threshold is compared live so lowering it mid-count gates at once.
                if (activity) begin
                    state_d    = StOn;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= cfg_idle_thresh) begin
                    state_d = StOff;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            StOff: begin
                if (activity) begin
                    state_d    = StWake;
                    wake_cnt_d = '0;
                end
            end
            StWake: begin
                // No abort path: wake always completes to ON.
                if (wake_cnt_q == WakeLast) begin
                    state_d    = StOn;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: state_d = StOn;
        endcase

        en_d = (state_d != StOff);

        gated_cnt_d = gated_cnt_q;
        if (cfg_cnt_clr) begin
            gated_cnt_d = '0;
        end else if (state_q == StOff && gated_cnt_q != '1) begin
            gated_cnt_d = gated_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= StOn;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            ack_q       <= '0;
            en_q        <= 1'b1;
            gated_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            ack_q       <= ack_d;
            en_q        <= en_d;
            gated_cnt_q <= gated_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign en        = en_q;
    assign state     = state_q;
    assign gated_cnt = gated_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Scoreboard bench for clock_gate_ctrl: a cycle-level reference model queues the expected
// outputs as stimulus is applied; a monitor pops and compares after every clock edge.
module tb_clock_gate_ctrl;

    localparam int NREQ  = 4;
    localparam int WAKE  = 2;
    localparam int GW    = 6;
    localparam int GMAX  = (1 << GW) - 1;

    localparam int M_ON   = 0;
    localparam int M_IDLE = 1;
    localparam int M_OFF  = 2;
    localparam int M_WAKE = 3;

    typedef struct packed {
        logic [1:0]      st;
        logic            en;
        logic [NREQ-1:0] ack;
        logic [GW-1:0]   gc;
    } obs_t;

    logic            clk = 1'b1;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] busy = '0;
    logic            cfg_auto_en = 1'b1;
    logic            cfg_force_on = 1'b0;
    logic [7:0]      cfg_idle_thresh = 8'd3;
    logic            cfg_cnt_clr = 1'b0;
    logic [NREQ-1:0] ack;
    logic            en;
    logic [1:0]      state;
    logic [GW-1:0]   gated_cnt;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    // Reference model state, advanced once per applied vector.
    int              m_state = M_ON;
    int              m_idle = 0;
    int              m_wake_left = 0;
    int              m_gcnt = 0;
    logic [NREQ-1:0] m_ack = '0;

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .NUM_REQ     (NREQ),
        .IDLE_CNT_W  (8),
        .WAKE_CYCLES (WAKE),
        .GCNT_W      (GW)
    ) dut (
        .clkin           (clk),
        .rst             (rst),
        .req             (req),
        .ack             (ack),
        .busy            (busy),
        .cfg_auto_en     (cfg_auto_en),
        .cfg_force_on    (cfg_force_on),
        .cfg_idle_thresh (cfg_idle_thresh),
        .cfg_cnt_clr     (cfg_cnt_clr),
        .en              (en),
        .state           (state),
        .gated_cnt       (gated_cnt)
    );

    task automatic model_edge();
        bit act;
        if (rst) begin
            m_state     = M_ON;
            m_idle      = 0;
            m_wake_left = 0;
            m_gcnt      = 0;
            m_ack       = '0;
            return;
        end
        act = (req != 0) || (busy != 0) || cfg_force_on || !cfg_auto_en;
        if (cfg_cnt_clr) m_gcnt = 0;
        else if (m_state == M_OFF) m_gcnt = (m_gcnt < GMAX) ? m_gcnt + 1 : GMAX;
        m_ack = (m_state == M_ON) ? req : '0;
        if (m_state == M_ON) begin
            if (!act) begin
                m_state = M_IDLE;
                m_idle  = 0;
            end
        end else if (m_state == M_IDLE) begin
            if (act) m_state = M_ON;
            else if (m_idle >= int'(cfg_idle_thresh)) m_state = M_OFF;
            else m_idle++;
        end else if (m_state == M_OFF) begin
            if (act) begin
                m_state     = M_WAKE;
                m_wake_left = WAKE;
            end
        end else begin
            m_wake_left--;
            if (m_wake_left == 0) m_state = M_ON;
        end
    endtask

    task automatic apply(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] bs,
                         input logic ae, input logic fo, input logic [7:0] th, input logic cc);
        obs_t e;
        @(negedge clk);
        rst = r; req = rq; busy = bs; cfg_auto_en = ae; cfg_force_on = fo;
        cfg_idle_thresh = th; cfg_cnt_clr = cc;
        model_edge();
        e.st  = 2'(m_state);
        e.en  = (m_state != M_OFF);
        e.ack = m_ack;
        e.gc  = GW'(m_gcnt);
        exp_q.push_back(e);
    endtask

    task automatic quiet(input int n, input logic [7:0] th);
        for (int k = 0; k < n; k++) apply(1'b0, '0, '0, 1'b1, 1'b0, th, 1'b0);
    endtask

    // Monitor: every edge presents a full output word.
    initial begin
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            got = '{st: state, en: en, ack: ack, gc: gated_cnt};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got %b with no expected entry, required queued entry",
                         cycle, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL cycle %0d state/en/ack/gcnt: got %b/%b/%b/%0d, required %b/%b/%b/%0d",
                             cycle, got.st, got.en, got.ack, got.gc, e.st, e.en, e.ack, e.gc);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rq, bs;
        logic [7:0]      th;
        apply(1'b1, '0, '0, 1'b1, 1'b0, 8'd3, 1'b0);
        apply(1'b1, '0, '0, 1'b1, 1'b0, 8'd3, 1'b0);
        // Threshold 3: one ON cycle, four IDLE, then gated.
        quiet(10, 8'd3);
        // Wake on REQ[2], hold until well past ACK, then release.
        for (int k = 0; k < 5; k++) apply(1'b0, 4'b0100, '0, 1'b1, 1'b0, 8'd3, 1'b0);
        quiet(3, 8'd3);
        // One-cycle BUSY pulse mid idle count.
        apply(1'b0, '0, 4'b0001, 1'b1, 1'b0, 8'd3, 1'b0);
        quiet(8, 8'd3);
        // Auto gating disabled wakes from OFF.
        for (int k = 0; k < 5; k++) apply(1'b0, '0, '0, 1'b0, 1'b0, 8'd200, 1'b0);
        // Lower threshold mid count, then run long enough to saturate the gated counter.
        quiet(52, 8'd200);
        quiet(22, 8'd5);
        quiet(60, 8'd5);
        apply(1'b0, '0, '0, 1'b1, 1'b0, 8'd5, 1'b1);
        quiet(3, 8'd5);
        // Reset while gated, then force-on holds the clock.
        apply(1'b1, '0, '0, 1'b1, 1'b0, 8'd5, 1'b0);
        quiet(2, 8'd5);
        for (int k = 0; k < 30; k++) apply(1'b0, '0, '0, 1'b1, 1'b1, 8'd0, 1'b0);
        // Randomised traffic; requesters hold REQ until the model grants ACK.
        rq = '0;
        th = 8'd2;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i]) rq[i] = ($urandom_range(63) == 0);
                else if (m_ack[i]) rq[i] = ($urandom_range(2) != 0);
            end
            for (int i = 0; i < NREQ; i++) bs[i] = ($urandom_range(31) == 0);
            if ($urandom_range(31) == 0) th = 8'($urandom_range(7));
            apply(($urandom_range(299) == 0), rq, bs, ($urandom_range(59) != 0),
                  ($urandom_range(59) == 0), th, ($urandom_range(63) == 0));
        end
        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
